// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // Value loaded into the wait counter when a read leaves ISSUE.
    function automatic logic [1:0] lat_load(input int rd_lat);
        return 2'(rd_lat - 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle of the arbiter; slave = arbiter side.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic [DW-1:0] ls_rdata;
    logic          ls_ack;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;
    logic          busy;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_data_out,
        output if_rdata, if_ack, ls_rdata, ls_ack,
               mem_read, mem_write, mem_address, mem_data_in, busy
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_data_out,
        input  if_rdata, if_ack, ls_rdata, ls_ack,
               mem_read, mem_write, mem_address, mem_data_in, busy
    );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Grant selection between fetch and load/store; with both requesting, the
// port not granted last wins. A constant rr_last_i = PORT_IF gives ls priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req_i,
    input  logic ls_req_i,
    input  logic rr_last_i,
    output logic grant_o
);

    always_comb begin
        grant_o = PORT_IF;
        if (if_req_i && ls_req_i) begin
            grant_o = (rr_last_i == PORT_LS) ? PORT_IF : PORT_LS;
        end else if (ls_req_i) begin
            grant_o = PORT_LS;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter/sequencer sharing one memory port between fetch and load/store.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is ls-over-if priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          port_q, port_d;
    logic [AW-1:0] mem_address_q, mem_address_d;
    logic [DW-1:0] mem_data_in_q, mem_data_in_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic          if_ack_q, if_ack_d;
    logic          ls_ack_q, ls_ack_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] ls_rdata_q, ls_rdata_d;
    logic          busy_q;

    logic          if_req_m, ls_req_m, grant, rr_last;

    // A port whose ack is showing this cycle is still holding its old request.
    assign if_req_m = bus.if_req & ~if_ack_q;
    assign ls_req_m = bus.ls_req & ~ls_ack_q;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= PORT_IF;
        end else if (state_q == IDLE && (if_req_m || ls_req_m)) begin
            rr_q <= grant;
        end
    end

    assign rr_last = rr_q;
`else
    assign rr_last = PORT_IF;
`endif

    mem_arb_pick u_pick (
        .if_req_i  (if_req_m),
        .ls_req_i  (ls_req_m),
        .rr_last_i (rr_last),
        .grant_o   (grant)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        port_d        = port_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        if_ack_d      = 1'b0;
        ls_ack_d      = 1'b0;
        if_rdata_d    = if_rdata_q;
        ls_rdata_d    = ls_rdata_q;
        case (state_q)
            IDLE: begin
                if (if_req_m || ls_req_m) begin
                    port_d  = grant;
                    state_d = ISSUE;
                    if (grant == PORT_LS) begin
                        mem_address_d = bus.ls_addr;
                        mem_data_in_d = bus.ls_wdata;
                        mem_write_d   = bus.ls_we;
                        mem_read_d    = ~bus.ls_we;
                    end else begin
                        mem_address_d = bus.if_addr;
                        mem_read_d    = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (mem_write_q) begin
                    state_d  = IDLE;
                    ls_ack_d = 1'b1;
                end else begin
                    cnt_d   = lat_load(RD_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = IDLE;
                    if (port_q == PORT_LS) begin
                        ls_rdata_d = bus.mem_data_out;
                        ls_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = bus.mem_data_out;
                        if_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            port_q        <= PORT_IF;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            if_ack_q      <= 1'b0;
            ls_ack_q      <= 1'b0;
            if_rdata_q    <= '0;
            ls_rdata_q    <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            port_q        <= port_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            if_ack_q      <= if_ack_d;
            ls_ack_q      <= ls_ack_d;
            if_rdata_q    <= if_rdata_d;
            ls_rdata_q    <= ls_rdata_d;
            busy_q        <= (state_d != IDLE);
        end
    end

    assign bus.if_rdata    = if_rdata_q;
    assign bus.if_ack      = if_ack_q;
    assign bus.ls_rdata    = ls_rdata_q;
    assign bus.ls_ack      = ls_ack_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data_in = mem_data_in_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench: dut_a uses RD_LAT=1, dut_b uses RD_LAT=3.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   ord   [8];
    int   ack_t [8];
    int   n_ack;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(16), .DW(16)) ba ();
    mem_port_arbiter_if #(.AW(16), .DW(16)) bb ();

    mem_port_arbiter #(.AW(16), .DW(16), .RD_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(ba.slave));
    mem_port_arbiter #(.AW(16), .DW(16), .RD_LAT(3)) dut_b (.clk(clk), .rst(rst), .bus(bb.slave));

    // Memory models; non-valid cycles carry an 0xE--- marker so stale captures show.
    logic [15:0] mem_a [0:255];
    logic [15:0] mem_b [0:255];
    logic [15:0] pa0, pb0, pb1, pb2;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 16'h0000;
                mem_b[i] <= 16'h0000;
            end
            mem_a[0] <= 16'hCD2B;
            mem_b[1] <= 16'h5A5A;
        end else begin
            if (ba.mem_write) mem_a[ba.mem_address[7:0]] <= ba.mem_data_in;
            if (bb.mem_write) mem_b[bb.mem_address[7:0]] <= bb.mem_data_in;
        end
        pa0 <= ba.mem_read ? mem_a[ba.mem_address[7:0]] : {4'hE, cyc[11:0]};
        pb0 <= bb.mem_read ? mem_b[bb.mem_address[7:0]] : {4'hE, cyc[11:0]};
        pb1 <= pb0;
        pb2 <= pb1;
    end

    assign ba.mem_data_out = pa0;
    assign bb.mem_data_out = pb2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Runs dut_a for a fixed budget with whatever requests are set, logging acks.
    task automatic run_pair(input int budget, input int n_target, input bit hold,
                            input logic [15:0] exp_if, input logic [15:0] exp_ls);
        int overlap = 0;
        int dual    = 0;
        n_ack = 0;
        for (int i = 0; i < 8; i++) begin
            ord[i]   = -1;
            ack_t[i] = -1;
        end
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (ba.mem_read && ba.mem_write) dual++;
            if (ba.if_ack && ba.ls_ack) overlap++;
            if (ba.if_ack) begin
                if (n_ack < 8) begin ord[n_ack] = 0; ack_t[n_ack] = c; end
                n_ack++;
                check("pair_if_rdata", ba.if_rdata, exp_if);
                if (!hold) ba.if_req = 1'b0;
            end
            if (ba.ls_ack) begin
                if (n_ack < 8) begin ord[n_ack] = 1; ack_t[n_ack] = c; end
                n_ack++;
                check("pair_ls_rdata", ba.ls_rdata, exp_ls);
                if (!hold) ba.ls_req = 1'b0;
            end
            if (n_ack >= n_target) begin
                ba.if_req = 1'b0;
                ba.ls_req = 1'b0;
            end
        end
        check("pair_ack_count", n_ack, n_target);
        check("pair_ack_overlap", overlap, 0);
        check("pair_dual_strobe", dual, 0);
    endtask

    initial begin
        int first_port;
        int acks_seen;
        rst = 1'b0;
        mem_init = 1'b1;
        ba.if_req = 1'b0; ba.if_addr = '0; ba.ls_req = 1'b0; ba.ls_we = 1'b0;
        ba.ls_addr = '0; ba.ls_wdata = '0;
        bb.if_req = 1'b0; bb.if_addr = '0; bb.ls_req = 1'b0; bb.ls_we = 1'b0;
        bb.ls_addr = '0; bb.ls_wdata = '0;
        repeat (3) step();

        check("rst_if_ack", ba.if_ack, 1'b0);
        check("rst_ls_ack", ba.ls_ack, 1'b0);
        check("rst_mem_read", ba.mem_read, 1'b0);
        check("rst_mem_write", ba.mem_write, 1'b0);
        check("rst_mem_address", ba.mem_address, 16'h0000);
        check("rst_if_rdata", ba.if_rdata, 16'h0000);
        check("rst_busy", ba.busy, 1'b0);
        check("rst_b_busy", bb.busy, 1'b0);

        rst = 1'b1;
        mem_init = 1'b0;
        step();

        // Single fetch, RD_LAT=1
        ba.if_req = 1'b1; ba.if_addr = 16'h0000;
        step();
        check("fetch_c1_read", ba.mem_read, 1'b1);
        check("fetch_c1_write", ba.mem_write, 1'b0);
        check("fetch_c1_busy", ba.busy, 1'b1);
        check("fetch_c1_ack", ba.if_ack, 1'b0);
        step();
        check("fetch_c2_read", ba.mem_read, 1'b0);
        check("fetch_c2_ack", ba.if_ack, 1'b0);
        step();
        check("fetch_c3_ack", ba.if_ack, 1'b1);
        check("fetch_c3_rdata", ba.if_rdata, 16'hCD2B);
        ba.if_req = 1'b0;
        step();
        check("fetch_c4_ack", ba.if_ack, 1'b0);
        check("fetch_c4_busy", ba.busy, 1'b0);
        check("fetch_c4_rdata_hold", ba.if_rdata, 16'hCD2B);

        // Store then load back
        ba.ls_req = 1'b1; ba.ls_we = 1'b1; ba.ls_addr = 16'h0010; ba.ls_wdata = 16'hBEEF;
        step();
        check("store_c1_write", ba.mem_write, 1'b1);
        check("store_c1_read", ba.mem_read, 1'b0);
        check("store_c1_addr", ba.mem_address, 16'h0010);
        check("store_c1_data", ba.mem_data_in, 16'hBEEF);
        step();
        check("store_c2_ack", ba.ls_ack, 1'b1);
        check("store_c2_write", ba.mem_write, 1'b0);
        check("store_ls_rdata_untouched", ba.ls_rdata, 16'h0000);
        ba.ls_req = 1'b0; ba.ls_we = 1'b0;
        step();
        check("store_c3_ack", ba.ls_ack, 1'b0);
        ba.ls_req = 1'b1; ba.ls_addr = 16'h0010; ba.ls_wdata = 16'h1111;
        step();
        check("load_c1_read", ba.mem_read, 1'b1);
        check("load_c1_addr", ba.mem_address, 16'h0010);
        step();
        check("load_c2_ack", ba.ls_ack, 1'b0);
        step();
        check("load_c3_ack", ba.ls_ack, 1'b1);
        check("load_c3_rdata", ba.ls_rdata, 16'hBEEF);
        check("load_if_rdata_untouched", ba.if_rdata, 16'hCD2B);
        ba.ls_req = 1'b0;
        step();

        // Simultaneous requests after an ls grant: priority ls, round robin if
        ba.if_req = 1'b1; ba.if_addr = 16'h0000;
        ba.ls_req = 1'b1; ba.ls_we = 1'b0; ba.ls_addr = 16'h0010;
        run_pair(12, 2, 1'b0, 16'hCD2B, 16'hBEEF);
`ifdef ARB_ROUND_ROBIN_EN
        first_port = 0;
`else
        first_port = 1;
`endif
        check("both_first_port", ord[0], first_port);
        check("both_second_port", ord[1], 1 - first_port);
        check("both_first_ack_cycle", ack_t[0], 3);
        check("both_second_ack_cycle", ack_t[1], 6);

        // Reset during WAIT of an RD_LAT=3 read
        bb.if_req = 1'b1; bb.if_addr = 16'h0001;
        step();
        check("rstw_c1_read", bb.mem_read, 1'b1);
        step();
        check("rstw_c2_busy", bb.busy, 1'b1);
        rst = 1'b0;
        #1;
        check("rstw_busy", bb.busy, 1'b0);
        check("rstw_read", bb.mem_read, 1'b0);
        check("rstw_addr", bb.mem_address, 16'h0000);
        check("rstw_ack", bb.if_ack, 1'b0);
        check("rstw_a_if_rdata", ba.if_rdata, 16'h0000);
        check("rstw_a_ls_rdata", ba.ls_rdata, 16'h0000);
        bb.if_req = 1'b0;
        step();
        rst = 1'b1;
        acks_seen = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bb.if_ack || bb.ls_ack) acks_seen++;
        end
        check("rstw_no_ack", acks_seen, 0);

        // Reissued RD_LAT=3 read
        bb.if_req = 1'b1; bb.if_addr = 16'h0001;
        step();
        check("lat3_c1_read", bb.mem_read, 1'b1);
        check("lat3_c1_addr", bb.mem_address, 16'h0001);
        step();
        check("lat3_c2_read", bb.mem_read, 1'b0);
        step();
        step();
        check("lat3_c4_ack", bb.if_ack, 1'b0);
        step();
        check("lat3_c5_ack", bb.if_ack, 1'b1);
        check("lat3_c5_rdata", bb.if_rdata, 16'h5A5A);
        bb.if_req = 1'b0;
        step();
        check("lat3_c6_ack", bb.if_ack, 1'b0);
        check("lat3_c6_busy", bb.busy, 1'b0);

        // Both held for four accesses after reset
        ba.if_req = 1'b1; ba.if_addr = 16'h0000;
        ba.ls_req = 1'b1; ba.ls_we = 1'b0; ba.ls_addr = 16'h0010;
        run_pair(16, 4, 1'b1, 16'hCD2B, 16'hBEEF);
        check("hold_ord0", ord[0], 1);
        check("hold_ord1", ord[1], 0);
        check("hold_ord2", ord[2], 1);
        check("hold_ord3", ord[3], 0);
        check("hold_t0", ack_t[0], 3);
        check("hold_t1", ack_t[1], 6);
        check("hold_t2", ack_t[2], 9);
        check("hold_t3", ack_t[3], 12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
